// File: rtl/mux_pkg.sv
// Shared constants and the lane selection function for the 8-to-1 lane mux.
package mux_pkg;

  localparam int NUM_LANES  = 8;
  localparam int SEL_W      = 4;
  localparam int LANE_IDX_W = 3;
  // Widest lane the selection function handles; callers zero-extend narrower lanes.
  localparam int MAX_LANE_W = 32;

  // Picks lane sel[2:0] from a packed vector of lanes that are `width` bits wide.
  // Codes 8..15 select all zeros; an unknown select gives X in 4-state simulation.
  function automatic logic [MAX_LANE_W-1:0] lane_sel(
    input logic [NUM_LANES*MAX_LANE_W-1:0] din,
    input logic [SEL_W-1:0]                sel,
    input int                              width
  );
    logic [MAX_LANE_W-1:0] mask;
    logic [MAX_LANE_W-1:0] lane;
    logic [LANE_IDX_W-1:0] idx;
    idx  = sel[LANE_IDX_W-1:0];
    // Shifting all-ones by the full lane width yields zero, so the mask covers MAX_LANE_W too.
    mask = ~({MAX_LANE_W{1'b1}} << width);
    lane = MAX_LANE_W'(din >> (int'(idx) * width)) & mask;
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7:     lane_sel = lane;
      4'd8, 4'd9, 4'd10, 4'd11,
      4'd12, 4'd13, 4'd14, 4'd15: lane_sel = '0;
      default:                    lane_sel = 'x;
    endcase
  endfunction

endpackage

// File: rtl/mux_8to1_core.sv
// Purely combinational lane selector: no state, no reset.
module mux_8to1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           y_comb
);

  logic [NUM_LANES*MAX_LANE_W-1:0] din_ext;

  // Zero-extend the packed lanes into the fixed-size vector the package function expects.
  always_comb begin
    din_ext = '0;
    din_ext[NUM_LANES*WIDTH-1:0] = din;
  end

  // Select the lane and keep only the low WIDTH bits.
  always_comb begin
    y_comb = WIDTH'(lane_sel(din_ext, sel, WIDTH));
  end

endmodule

// File: rtl/mux_8to1.sv
// Registered 8-to-1 lane mux: combinational output, enabled register, and an
// out-of-range select flag captured alongside the registered lane.
module mux_8to1
  import mux_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       en,
  output logic [WIDTH-1:0]           y_comb,
  output logic [WIDTH-1:0]           y,
  output logic                       sel_err
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             sel_err_d;
  logic             sel_err_q;

  mux_8to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .din    (din),
    .sel    (sel),
    .y_comb (y_comb)
  );

  // Next-state: load the selected lane and the out-of-range bit when enabled, else hold.
  always_comb begin
    y_d       = y_q;
    sel_err_d = sel_err_q;
    if (en) begin
      y_d       = y_comb;
      sel_err_d = sel[LANE_IDX_W];
    end
  end

  // Output registers; reset clears them immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= RESET_VAL;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign y       = y_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_8to1.sv
// Directed bench for mux_8to1 with the default 1-bit lane width.
module tb_mux_8to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] sel;
  logic       en;
  logic       y_comb;
  logic       y;
  logic       sel_err;

  int total = 0;
  int bad   = 0;

  mux_8to1 #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .sel     (sel),
    .en      (en),
    .y_comb  (y_comb),
    .y       (y),
    .sel_err (sel_err)
  );

  // Clock: 10 time-unit period, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, check y_comb right away, then check the
  // registered outputs just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] d, input logic [3:0] s,
                      input logic e, input logic exp_comb, input logic exp_y,
                      input logic exp_err);
    @(negedge clk);
    din = d;
    sel = s;
    en  = e;
    #1;
    check({tag, "_comb"}, {7'd0, y_comb}, {7'd0, exp_comb});
    @(posedge clk);
    #1;
    check({tag, "_y"}, {7'd0, y}, {7'd0, exp_y});
    check({tag, "_err"}, {7'd0, sel_err}, {7'd0, exp_err});
  endtask

  initial begin
    // Reset asserted from time zero; check before the first clock edge.
    rst_n = 1'b0;
    din   = 8'hFF;
    sel   = 4'd1;
    en    = 1'b0;
    #1;
    check("rst_y", {7'd0, y}, 8'd0);
    check("rst_err", {7'd0, sel_err}, 8'd0);
    check("rst_comb", {7'd0, y_comb}, 8'd1);
    // Reset held across an edge with en high: outputs stay cleared.
    en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_y", {7'd0, y}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Even selects.
    step("even0", 8'b1011_1010, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("even2", 8'b1011_1010, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step("even4", 8'b1011_1010, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step("even6", 8'b1011_1010, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    // Odd selects.
    step("odd1", 8'b1011_1010, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("odd3", 8'b1011_1010, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step("odd5", 8'b1011_1010, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("odd7", 8'b1011_1010, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    // Out-of-range codes, then back in range.
    step("oor8",  8'hFF, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1);
    step("oor15", 8'hFF, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    step("oor_back3", 8'hFF, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // Hold: load 1, then drop en and clear din.
    step("hold_load", 8'h10, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step("hold_c1", 8'h00, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step("hold_c2", 8'h00, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step("hold_c3", 8'h00, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step("hold_en", 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Held out-of-range flag also ignores select changes while en is low.
    step("err_set", 8'hFF, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    step("err_hold", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);

    // Async reset between edges while y=1 and then with sel_err=1.
    step("pre_rst", 8'h10, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y", {7'd0, y}, 8'd0);
    check("async_err", {7'd0, sel_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 8'h10, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);

    step("pre_rst2", 8'hFF, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async2_err", {7'd0, sel_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst2", 8'b1000_0000, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
